// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the sequencer state encoding and the jump_cond opcodes decoded by the next-PC logic.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERR   = 2'd3
    } seq_state_t;

    localparam logic [3:0] COND_JEQ  = 4'b0001;
    localparam logic [3:0] COND_JNE  = 4'b0010;
    localparam logic [3:0] COND_CALL = 4'b0011;
    localparam logic [3:0] COND_RET  = 4'b0100;
    localparam logic [3:0] COND_JMP  = 4'b1111;

    // True when a plain (non-stack) transfer loads target_addr; unknown codes fall through to pc+1.
    function automatic logic branch_taken(input logic [3:0] cond, input logic zero);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_JMP: taken = 1'b1;
            COND_JEQ: taken = zero;
            COND_JNE: taken = ~zero;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET. Only the occupancy count is reset; entry contents persist.
// The top-of-stack word is read combinationally so a RET can load it into the PC in the same cycle.
module ret_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] din_i,
    output logic [ADDR_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx  = count_q[IDX_W-1:0];
    assign rd_idx  = wr_idx - IDX_W'(1);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_idx];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the 8-bit CPU program counter.
// Fetches over a req/ack handshake, waits for exec_done, then resolves the next PC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               is_jump,
    input  logic [3:0]         jump_cond,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic               flag_z,
    output logic [ADDR_W-1:0]  pc,
    output logic               err_overflow,
    output logic               err_underflow
);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               unf_q;
    logic               unf_d;

    logic               stk_push;
    logic               stk_pop;
    logic               stk_full;
    logic               stk_empty;
    logic [ADDR_W-1:0]  stk_dout;
    logic [ADDR_W-1:0]  pc_inc;

    // Natural wrap: 0xFF + 1 = 0x00, also used as the pushed return address.
    assign pc_inc = pc_q + ADDR_W'(1);

    ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .srst    (reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_inc),
        .dout_o  (stk_dout),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                    if (is_jump) begin
                        case (jump_cond)
                            COND_CALL: begin
                                if (stk_full) begin
                                    ovf_d   = 1'b1;
                                    state_d = ST_ERR;
                                    pc_d    = pc_q;
                                end else begin
                                    stk_push = 1'b1;
                                    pc_d     = target_addr;
                                end
                            end
                            COND_RET: begin
                                if (stk_empty) begin
                                    unf_d   = 1'b1;
                                    state_d = ST_ERR;
                                    pc_d    = pc_q;
                                end else begin
                                    stk_pop = 1'b1;
                                    pc_d    = stk_dout;
                                end
                            end
                            default: begin
                                if (branch_taken(jump_cond, flag_z)) begin
                                    pc_d = target_addr;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign imem_req      = (state_q == ST_FETCH);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == ST_EXEC);
    assign pc            = pc_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_EXEC && exec_done && state_d == ST_FETCH) begin
                $display("pc_sequencer: pc %h -> %h", pc_q, pc_d);
            end
            if (ovf_d && !ovf_q) begin
                $display("pc_sequencer: stack overflow on CALL at pc %h", pc_q);
            end
            if (unf_d && !unf_q) begin
                $display("pc_sequencer: stack underflow on RET at pc %h", pc_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus queues expected (pc, instr) per fetch,
// a negedge monitor pops and checks each time the DUT enters EXEC.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        is_jump;
    logic [3:0]  jump_cond;
    logic [7:0]  target_addr;
    logic        flag_z;
    logic [7:0]  pc;
    logic        err_overflow;
    logic        err_underflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (8),
        .INSTR_W   (16),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .is_jump       (is_jump),
        .jump_cond     (jump_cond),
        .target_addr   (target_addr),
        .flag_z        (flag_z),
        .pc            (pc),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of instr_valid is one executed instruction.
    logic iv_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && !iv_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL exec_unexpected: got pc=%h instr=%h, required no execution", pc, instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("exec_pc", {24'h0, pc}, {24'h0, mon_e.addr});
                chk("exec_instr", {16'h0, instr}, {16'h0, mon_e.data});
                $display("exec pc=%h instr=%h", pc, instr);
            end
        end
        iv_prev = (instr_valid === 1'b1);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", {24'h0, pc}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_errs", {30'h0, err_overflow, err_underflow}, 32'h0);
        reset = 1'b0;
    endtask

    // One instruction: wait for request, ack after ack_dly cycles, done after done_dly cycles.
    task automatic run_instr(input logic [7:0] a, input int ack_dly, input int done_dly,
                             input logic [15:0] data, input logic j, input logic [3:0] c,
                             input logic [7:0] tgt, input logic z, output int wait_n);
        exp_q.push_back({a, data});
        wait_n = 0;
        while (imem_req !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'h0, imem_req}, 32'h1);
            return;
        end
        chk("fetch_addr", {24'h0, imem_addr}, {24'h0, a});
        chk("fetch_no_valid", {31'h0, instr_valid}, 32'h0);
        repeat (ack_dly) begin
            @(negedge clk);
            chk("req_hold", {31'h0, imem_req}, 32'h1);
            chk("addr_hold", {24'h0, imem_addr}, {24'h0, a});
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        chk("exec_valid", {31'h0, instr_valid}, 32'h1);
        repeat (done_dly) begin
            @(negedge clk);
            chk("exec_wait", {31'h0, instr_valid}, 32'h1);
        end
        exec_done   = 1'b1;
        is_jump     = j;
        jump_cond   = c;
        target_addr = tgt;
        flag_z      = z;
        @(negedge clk);
        exec_done   = 1'b0;
        is_jump     = 1'b0;
        jump_cond   = 4'h0;
        target_addr = 8'h0;
        flag_z      = 1'b0;
        chk("exec_end", {31'h0, instr_valid}, 32'h0);
    endtask

    task automatic seq(input logic [7:0] a, output int w);
        run_instr(a, 0, 0, {8'h5A, a}, 1'b0, 4'h0, 8'h00, 1'b0, w);
    endtask

    task automatic jmp(input logic [7:0] a, input logic [3:0] c, input logic [7:0] t,
                       input logic z);
        int w;
        run_instr(a, 0, 0, {8'hB0, a}, 1'b1, c, t, z, w);
    endtask

    initial begin
        int w;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; exec_done = 1'b0;
        is_jump = 1'b0; jump_cond = 4'h0; target_addr = 8'h0; flag_z = 1'b0;
        @(negedge clk);
        do_reset();

        // Back-to-back sequential fetches at 2 cycles per instruction.
        seq(8'h00, w); chk("first_fetch_lat", w, 1);
        seq(8'h01, w); chk("thru_1", w, 0);
        seq(8'h02, w); chk("thru_2", w, 0);
        run_instr(8'h03, 0, 2, 16'h0303, 1'b0, 4'h0, 8'h00, 1'b0, w);
        seq(8'h04, w);
        // Delayed ack at 0x05, then CALL/RET round-trip.
        run_instr(8'h05, 3, 0, 16'hA5C3, 1'b1, COND_CALL, 8'h40, 1'b0, w);
        jmp(8'h40, COND_RET, 8'hEE, 1'b0);
        jmp(8'h06, COND_JMP, 8'h20, 1'b0);
        jmp(8'h20, COND_JEQ, 8'h30, 1'b0);
        jmp(8'h21, COND_JEQ, 8'h30, 1'b1);
        jmp(8'h30, COND_JNE, 8'h40, 1'b1);
        jmp(8'h31, COND_JNE, 8'h50, 1'b0);
        jmp(8'h50, 4'b0111, 8'h99, 1'b1);
        jmp(8'h51, COND_JMP, 8'hFF, 1'b0);
        seq(8'hFF, w);
        jmp(8'h00, COND_JMP, 8'hFF, 1'b0);
        jmp(8'hFF, COND_CALL, 8'h60, 1'b0);
        jmp(8'h60, COND_RET, 8'h00, 1'b0);
        jmp(8'h00, COND_CALL, 8'h70, 1'b0);
        jmp(8'h70, COND_CALL, 8'h80, 1'b0);
        jmp(8'h80, COND_RET, 8'h00, 1'b0);
        jmp(8'h71, COND_RET, 8'h00, 1'b0);
        jmp(8'h01, COND_CALL, 8'h10, 1'b0);
        jmp(8'h10, COND_CALL, 8'h11, 1'b0);
        jmp(8'h11, COND_CALL, 8'h12, 1'b0);
        jmp(8'h12, COND_CALL, 8'h13, 1'b0);
        jmp(8'h13, COND_CALL, 8'h14, 1'b0);
        chk("ovf_flag", {31'h0, err_overflow}, 32'h1);
        chk("ovf_unf_clear", {31'h0, err_underflow}, 32'h0);
        chk("ovf_req", {31'h0, imem_req}, 32'h0);
        chk("ovf_pc", {24'h0, pc}, 32'h13);
        repeat (3) @(negedge clk);
        chk("err_stay_req", {31'h0, imem_req}, 32'h0);
        chk("err_stay_valid", {31'h0, instr_valid}, 32'h0);
        chk("err_stay_pc", {24'h0, pc}, 32'h13);

        // Underflow on RET straight after reset.
        do_reset();
        jmp(8'h00, COND_RET, 8'h55, 1'b0);
        chk("unf_flag", {31'h0, err_underflow}, 32'h1);
        chk("unf_req", {31'h0, imem_req}, 32'h0);
        chk("unf_pc", {24'h0, pc}, 32'h0);
        do_reset();

        // Reset during FETCH with a late ack.
        seq(8'h00, w);
        chk("pre_abort_addr", {24'h0, imem_addr}, 32'h01);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_pc", {24'h0, pc}, 32'h0);
        chk("abort_req", {31'h0, imem_req}, 32'h0);
        chk("abort_valid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 16'h0;
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", {24'h0, imem_addr}, 32'h0);
        chk("restart_valid", {31'h0, instr_valid}, 32'h0);
        chk("restart_instr", {16'h0, instr}, 32'h0);
        seq(8'h00, w); chk("restart_lat", w, 0);
        seq(8'h01, w);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
